// File: rtl/alu_issue_pkg.sv
// Shared RV32I encodings, ALU opcode constants and the issue-entry layout.
package alu_issue_pkg;

    localparam int unsigned XLEN_P  = 32;
    localparam int unsigned OPC_W_P = 8;
    localparam int unsigned REG_W   = 5;

    // RV32I major opcodes handled by this stage
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // ALU opcodes; SUB shares the ADD code and SLT shares the SRA code, alu_op selects
    localparam logic [OPC_W_P-1:0] ALU_ADD  = 8'h00;
    localparam logic [OPC_W_P-1:0] ALU_SUB  = ALU_ADD;
    localparam logic [OPC_W_P-1:0] ALU_XOR  = 8'h01;
    localparam logic [OPC_W_P-1:0] ALU_OR   = 8'h02;
    localparam logic [OPC_W_P-1:0] ALU_AND  = 8'h03;
    localparam logic [OPC_W_P-1:0] ALU_SLL  = 8'h04;
    localparam logic [OPC_W_P-1:0] ALU_SRL  = 8'h05;
    localparam logic [OPC_W_P-1:0] ALU_SRA  = 8'h06;
    localparam logic [OPC_W_P-1:0] ALU_SLT  = ALU_SRA;
    localparam logic [OPC_W_P-1:0] ALU_SLTU = 8'h07;

    typedef struct packed {
        logic [XLEN_P-1:0]  op1;
        logic [XLEN_P-1:0]  op2;
        logic [OPC_W_P-1:0] opcode;
        logic               alu_op;
        logic [REG_W-1:0]   rd;
        logic               we;
        logic               illegal;
    } issue_entry_t;

    // ALU opcode for a funct3; alt selects the arithmetic right shift
    function automatic logic [OPC_W_P-1:0] alu_code(input logic [2:0] f3, input logic alt);
        logic [OPC_W_P-1:0] code;
        unique case (f3)
            F3_ADD:  code = alt ? ALU_SUB : ALU_ADD;
            F3_SLL:  code = ALU_SLL;
            F3_SLT:  code = ALU_SLT;
            F3_SLTU: code = ALU_SLTU;
            F3_XOR:  code = ALU_XOR;
            F3_SR:   code = alt ? ALU_SRA : ALU_SRL;
            F3_OR:   code = ALU_OR;
            default: code = ALU_AND;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational RV32I OP/OP-IMM/LUI/AUIPC decode into an ALU issue entry.
// Ports: inst_i, pc_i, rs1_data_i, rs2_data_i in; entry_c out (combinational).
module alu_issue_decode
    import alu_issue_pkg::*;
(
    input  logic [31:0]  inst_i,
    input  logic [31:0]  pc_i,
    input  logic [31:0]  rs1_data_i,
    input  logic [31:0]  rs2_data_i,
    output issue_entry_t entry_c
);

    logic [6:0]  major;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        alt;
    logic        is_shift;
    logic [31:0] u_imm;
    logic [31:0] i_imm;
    logic [31:0] shamt;

    assign major    = inst_i[6:0];
    assign f3       = inst_i[14:12];
    assign f7       = inst_i[31:25];
    assign alt      = (f7 == F7_ALT);
    assign is_shift = (f3 == F3_SLL) || (f3 == F3_SR);
    assign u_imm    = {inst_i[31:12], 12'b0};
    assign i_imm    = {{20{inst_i[31]}}, inst_i[31:20]};
    assign shamt    = {27'b0, inst_i[24:20]};

    always_comb begin
        entry_c        = '0;
        entry_c.rd     = inst_i[11:7];
        entry_c.opcode = ALU_ADD;
        unique case (major)
            OPC_OP: begin
                entry_c.op1     = rs1_data_i;
                entry_c.op2     = is_shift ? {27'b0, rs2_data_i[4:0]} : rs2_data_i;
                entry_c.opcode  = alu_code(f3, alt);
                entry_c.alu_op  = alt;
                entry_c.illegal = !((f7 == F7_BASE) || (alt && ((f3 == F3_ADD) || (f3 == F3_SR))));
            end
            OPC_OP_IMM: begin
                // imm[10] only means SRAI on a right shift; elsewhere it is immediate data
                entry_c.op1     = rs1_data_i;
                entry_c.op2     = is_shift ? shamt : i_imm;
                entry_c.opcode  = alu_code(f3, alt && (f3 == F3_SR));
                entry_c.alu_op  = alt && (f3 == F3_SR);
                entry_c.illegal = ((f3 == F3_SLL) && (f7 != F7_BASE))
                               || ((f3 == F3_SR) && (f7 != F7_BASE) && !alt);
            end
            OPC_LUI: begin
                entry_c.op2 = u_imm;
            end
            OPC_AUIPC: begin
                entry_c.op1 = pc_i;
                entry_c.op2 = u_imm;
            end
            default: begin
                entry_c.illegal = 1'b1;
            end
        endcase
        // every illegal entry carries neutral operands so EX sees a harmless ADD
        if (entry_c.illegal) begin
            entry_c.op1    = '0;
            entry_c.op2    = '0;
            entry_c.opcode = ALU_ADD;
            entry_c.alu_op = 1'b0;
        end
        entry_c.we = !entry_c.illegal && (entry_c.rd != '0);
    end

endmodule

// File: rtl/alu_issue.sv
// ALU issue stage: decodes the incoming instruction and holds it in a 2-entry
// skid buffer toward EX with valid/ready handshakes on both sides.
// Ports: clk_i, rst_ni (sync, active-low), flush_i; upstream inst_valid_i/
// inst_ready_o with inst_i, pc_i, rs1_data_i, rs2_data_i; downstream
// ex_valid_o/ex_ready_i with ex_op1_o, ex_op2_o, ex_opcode_o, ex_alu_op_o,
// ex_rd_o, ex_we_o, ex_illegal_o.
module alu_issue
    import alu_issue_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned OPC_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             inst_valid_i,
    output logic             inst_ready_o,
    input  logic [31:0]      inst_i,
    input  logic [XLEN-1:0]  pc_i,
    input  logic [XLEN-1:0]  rs1_data_i,
    input  logic [XLEN-1:0]  rs2_data_i,
    output logic             ex_valid_o,
    input  logic             ex_ready_i,
    output logic [XLEN-1:0]  ex_op1_o,
    output logic [XLEN-1:0]  ex_op2_o,
    output logic [OPC_W-1:0] ex_opcode_o,
    output logic             ex_alu_op_o,
    output logic [4:0]       ex_rd_o,
    output logic             ex_we_o,
    output logic             ex_illegal_o
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } buf_state_e;

    buf_state_e   state_q, state_d;
    issue_entry_t main_q, main_d;
    issue_entry_t skid_q, skid_d;
    issue_entry_t dec_entry;
    logic         valid_q, ready_q;
    logic         accept, xfer;

    alu_issue_decode u_decode (
        .inst_i     (inst_i),
        .pc_i       (32'(pc_i)),
        .rs1_data_i (32'(rs1_data_i)),
        .rs2_data_i (32'(rs2_data_i)),
        .entry_c    (dec_entry)
    );

    assign accept = inst_valid_i && ready_q;
    assign xfer   = valid_q && ex_ready_i;

    // State and entry registers
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            valid_q <= (state_d != ST_EMPTY);
            ready_q <= (state_d != ST_TWO);
        end
    end

    // Next-state and buffer data movement; main always holds the oldest entry
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        unique case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d = ST_ONE;
                    main_d  = dec_entry;
                end
            end
            ST_ONE: begin
                if (accept && xfer) begin
                    main_d = dec_entry;
                end else if (accept) begin
                    state_d = ST_TWO;
                    skid_d  = dec_entry;
                end else if (xfer) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (xfer) begin
                    state_d = ST_ONE;
                    main_d  = skid_q;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
        if (flush_i) begin
            state_d = ST_EMPTY;
            main_d  = main_q;
            skid_d  = skid_q;
        end
    end

    assign inst_ready_o = ready_q;
    assign ex_valid_o   = valid_q;
    assign ex_op1_o     = XLEN'(main_q.op1);
    assign ex_op2_o     = XLEN'(main_q.op2);
    assign ex_opcode_o  = OPC_W'(main_q.opcode);
    assign ex_alu_op_o  = main_q.alu_op;
    assign ex_rd_o      = main_q.rd;
    assign ex_we_o      = main_q.we;
    assign ex_illegal_o = main_q.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: decode vector table, handshake/flush/reset
// sequences, then random traffic against a queue-based reference model.
module tb_alu_issue;
    import alu_issue_pkg::*;

    logic        clk, rst_n, flush, inst_valid, inst_ready, ex_ready;
    logic [31:0] inst, pc, rs1, rs2;
    logic        ex_valid, ex_alu_op, ex_we, ex_illegal;
    logic [31:0] ex_op1, ex_op2;
    logic [7:0]  ex_opcode;
    logic [4:0]  ex_rd;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] op1;
        logic [31:0] op2;
        logic [7:0]  opcode;
        logic        alu_op;
        logic [4:0]  rd;
        logic        we;
        logic        illegal;
        logic        ops_dc;   // operand fields unconstrained for this entry
    } exp_t;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        exp_t        e;
    } vec_t;

    alu_issue dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .flush_i      (flush),
        .inst_valid_i (inst_valid),
        .inst_ready_o (inst_ready),
        .inst_i       (inst),
        .pc_i         (pc),
        .rs1_data_i   (rs1),
        .rs2_data_i   (rs2),
        .ex_valid_o   (ex_valid),
        .ex_ready_i   (ex_ready),
        .ex_op1_o     (ex_op1),
        .ex_op2_o     (ex_op2),
        .ex_opcode_o  (ex_opcode),
        .ex_alu_op_o  (ex_alu_op),
        .ex_rd_o      (ex_rd),
        .ex_we_o      (ex_we),
        .ex_illegal_o (ex_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input string field, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s.%s: got %h want %h", tag, field, act, exp);
        end
    endtask

    task automatic check_entry(input string tag, input exp_t e);
        check(tag, "valid", 32'(ex_valid), 32'd1);
        if (!e.ops_dc) begin
            check(tag, "op1", ex_op1, e.op1);
            check(tag, "op2", ex_op2, e.op2);
            check(tag, "opcode", 32'(ex_opcode), 32'(e.opcode));
            check(tag, "alu_op", 32'(ex_alu_op), 32'(e.alu_op));
        end
        check(tag, "rd", 32'(ex_rd), 32'(e.rd));
        check(tag, "we", 32'(ex_we), 32'(e.we));
        check(tag, "illegal", 32'(ex_illegal), 32'(e.illegal));
    endtask

    task automatic drive(input logic v, input logic [31:0] i, input logic [31:0] p,
                         input logic [31:0] a, input logic [31:0] b);
        inst_valid = v;
        inst = i;
        pc = p;
        rs1 = a;
        rs2 = b;
    endtask

    // Reference decode written per mnemonic from the ISA rules
    function automatic exp_t ref_decode(input logic [31:0] w, input logic [31:0] p,
                                        input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int unsigned f3, f7, imm12;
        logic [31:0] imm;
        f3 = 32'(w[14:12]);
        f7 = 32'(w[31:25]);
        imm12 = 32'(w[31:20]);
        imm = (imm12 >= 2048) ? imm12 - 32'd4096 : imm12;
        e = '{op1: a, op2: b, opcode: ALU_ADD, alu_op: 1'b0, rd: w[11:7],
              we: 1'b0, illegal: 1'b0, ops_dc: 1'b0};
        case (w[6:0])
            7'h33: begin
                if (f7 == 0) begin
                    case (f3)
                        0: e.opcode = ALU_ADD;
                        1: begin e.opcode = ALU_SLL; e.op2 = b % 32; end
                        2: e.opcode = ALU_SLT;
                        3: e.opcode = ALU_SLTU;
                        4: e.opcode = ALU_XOR;
                        5: begin e.opcode = ALU_SRL; e.op2 = b % 32; end
                        6: e.opcode = ALU_OR;
                        default: e.opcode = ALU_AND;
                    endcase
                end else if (f7 == 32 && f3 == 0) begin
                    e.opcode = ALU_SUB; e.alu_op = 1'b1;
                end else if (f7 == 32 && f3 == 5) begin
                    e.opcode = ALU_SRA; e.alu_op = 1'b1; e.op2 = b % 32;
                end else begin
                    e.illegal = 1'b1; e.ops_dc = 1'b1;
                end
            end
            7'h13: begin
                e.op2 = imm;
                case (f3)
                    0: e.opcode = ALU_ADD;
                    2: e.opcode = ALU_SLT;
                    3: e.opcode = ALU_SLTU;
                    4: e.opcode = ALU_XOR;
                    6: e.opcode = ALU_OR;
                    7: e.opcode = ALU_AND;
                    1: begin
                        e.opcode = ALU_SLL; e.op2 = imm12 % 32;
                        if (f7 != 0) begin e.illegal = 1'b1; e.ops_dc = 1'b1; end
                    end
                    default: begin
                        e.op2 = imm12 % 32;
                        if (f7 == 0) e.opcode = ALU_SRL;
                        else if (f7 == 32) begin e.opcode = ALU_SRA; e.alu_op = 1'b1; end
                        else begin e.illegal = 1'b1; e.ops_dc = 1'b1; end
                    end
                endcase
            end
            7'h37: begin e.op1 = 0; e.op2 = w & 32'hFFFF_F000; end
            7'h17: begin e.op1 = p; e.op2 = w & 32'hFFFF_F000; end
            default: begin e.illegal = 1'b1; e.op1 = 0; e.op2 = 0; end
        endcase
        e.we = !e.illegal && (e.rd != 0);
        return e;
    endfunction

    function automatic logic [31:0] gen_inst();
        logic [31:0] w;
        int unsigned sel;
        w = $urandom;
        sel = $urandom_range(0, 9);
        if (sel <= 3) begin
            w[6:0] = 7'h33;
            case ($urandom_range(0, 3))
                0, 1: w[31:25] = 7'h00;
                2: w[31:25] = 7'h20;
                default: ;
            endcase
        end else if (sel <= 6) begin
            w[6:0] = 7'h13;
            case ($urandom_range(0, 2))
                0: w[31:25] = 7'h00;
                1: w[31:25] = 7'h20;
                default: ;
            endcase
        end else if (sel == 7) begin
            w[6:0] = 7'h37;
        end else if (sel == 8) begin
            w[6:0] = 7'h17;
        end
        return w;
    endfunction

    vec_t vecs[13];
    exp_t model_q[$];

    initial begin
        // inst, pc, rs1, rs2, {op1, op2, opcode, alu_op, rd, we, illegal, ops_dc}
        vecs[0]  = '{32'h002081B3, 32'h0, 32'd5, 32'd7, '{32'd5, 32'd7, ALU_ADD, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0}};
        vecs[1]  = '{32'h402081B3, 32'h0, 32'd10, 32'd3, '{32'd10, 32'd3, ALU_SUB, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0}};
        vecs[2]  = '{32'h40415093, 32'h0, 32'h80000000, 32'd9, '{32'h80000000, 32'd4, ALU_SRA, 1'b1, 5'd1, 1'b1, 1'b0, 1'b0}};
        vecs[3]  = '{32'h002091B3, 32'h0, 32'd1, 32'h123, '{32'd1, 32'd3, ALU_SLL, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0}};
        vecs[4]  = '{32'hFFF00093, 32'h0, 32'd0, 32'd0, '{32'd0, 32'hFFFFFFFF, ALU_ADD, 1'b0, 5'd1, 1'b1, 1'b0, 1'b0}};
        vecs[5]  = '{32'h123452B7, 32'h0, 32'hDEAD, 32'hBEEF, '{32'd0, 32'h12345000, ALU_ADD, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0}};
        vecs[6]  = '{32'h00001397, 32'h100, 32'h55, 32'h66, '{32'h100, 32'h1000, ALU_ADD, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0}};
        vecs[7]  = '{32'h00000073, 32'h200, 32'h11, 32'h22, '{32'd0, 32'd0, ALU_ADD, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0}};
        vecs[8]  = '{32'h022081B3, 32'h0, 32'h11, 32'h22, '{32'd0, 32'd0, ALU_ADD, 1'b0, 5'd3, 1'b0, 1'b1, 1'b1}};
        vecs[9]  = '{32'hFFF0B213, 32'h0, 32'd1, 32'd0, '{32'd1, 32'hFFFFFFFF, ALU_SLTU, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0}};
        vecs[10] = '{32'h00500013, 32'h0, 32'd9, 32'd0, '{32'd9, 32'd5, ALU_ADD, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0}};
        vecs[11] = '{32'h40109093, 32'h0, 32'd9, 32'd0, '{32'd0, 32'd0, ALU_ADD, 1'b0, 5'd1, 1'b0, 1'b1, 1'b1}};
        vecs[12] = '{32'h0020A1B3, 32'h0, 32'hFFFFFFFF, 32'd1, '{32'hFFFFFFFF, 32'd1, ALU_SLT, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0}};

        rst_n = 1'b0;
        flush = 1'b0;
        ex_ready = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        repeat (2) @(negedge clk);
        check("reset", "valid", 32'(ex_valid), 32'd0);
        check("reset", "ready", 32'(inst_ready), 32'd1);
        check("reset", "op1", ex_op1, 32'd0);
        check("reset", "op2", ex_op2, 32'd0);
        check("reset", "rd_we_ill", {ex_rd, ex_we, ex_illegal, ex_alu_op}, 32'd0);
        rst_n = 1'b1;

        // Decode table: one instruction per cycle at full throughput
        ex_ready = 1'b1;
        for (int i = 0; i < 13; i++) begin
            drive(1'b1, vecs[i].inst, vecs[i].pc, vecs[i].rs1, vecs[i].rs2);
            @(negedge clk);
            inst_valid = 1'b0;
            check_entry($sformatf("vec%0d", i), vecs[i].e);
            check($sformatf("vec%0d", i), "ready", 32'(inst_ready), 32'd1);
        end
        @(negedge clk);
        check("drain", "valid", 32'(ex_valid), 32'd0);

        // Backpressure: third push is refused, then ordered drain at 1/cycle
        ex_ready = 1'b0;
        drive(1'b1, 32'h002081B3, 32'h0, 32'h111, 32'h1);
        @(negedge clk);
        check("bp1", "ready", 32'(inst_ready), 32'd1);
        drive(1'b1, 32'h002081B3, 32'h0, 32'h222, 32'h1);
        @(negedge clk);
        check("bp2", "ready", 32'(inst_ready), 32'd0);
        check("bp2", "op1", ex_op1, 32'h111);
        drive(1'b1, 32'h002081B3, 32'h0, 32'h333, 32'h1);
        @(negedge clk);
        check("bp3", "ready", 32'(inst_ready), 32'd0);
        check("bp3", "valid", 32'(ex_valid), 32'd1);
        check("bp3", "op1_stable", ex_op1, 32'h111);
        inst_valid = 1'b0;
        ex_ready = 1'b1;
        @(negedge clk);
        check("bp4", "valid", 32'(ex_valid), 32'd1);
        check("bp4", "op1", ex_op1, 32'h222);
        check("bp4", "ready", 32'(inst_ready), 32'd1);
        @(negedge clk);
        check("bp5", "valid", 32'(ex_valid), 32'd0);

        // Flush while full, with an incoming request
        ex_ready = 1'b0;
        drive(1'b1, 32'h002081B3, 32'h0, 32'h444, 32'h1);
        @(negedge clk);
        drive(1'b1, 32'h002081B3, 32'h0, 32'h555, 32'h1);
        @(negedge clk);
        flush = 1'b1;
        drive(1'b1, 32'h002081B3, 32'h0, 32'h666, 32'h1);
        @(negedge clk);
        flush = 1'b0;
        inst_valid = 1'b0;
        ex_ready = 1'b1;
        check("flush2", "valid", 32'(ex_valid), 32'd0);
        check("flush2", "ready", 32'(inst_ready), 32'd1);
        @(negedge clk);
        check("flush2b", "valid", 32'(ex_valid), 32'd0);

        // Flush with one entry held and an accept in the same cycle
        ex_ready = 1'b0;
        drive(1'b1, 32'h002081B3, 32'h0, 32'h777, 32'h1);
        @(negedge clk);
        flush = 1'b1;
        drive(1'b1, 32'h002081B3, 32'h0, 32'h888, 32'h1);
        @(negedge clk);
        flush = 1'b0;
        inst_valid = 1'b0;
        check("flush1", "valid", 32'(ex_valid), 32'd0);
        check("flush1", "ready", 32'(inst_ready), 32'd1);
        @(negedge clk);
        check("flush1b", "valid", 32'(ex_valid), 32'd0);

        // Reset mid-stream with the buffer full
        drive(1'b1, 32'h002081B3, 32'h0, 32'h999, 32'h1);
        @(negedge clk);
        drive(1'b1, 32'h002081B3, 32'h0, 32'hAAA, 32'h1);
        @(negedge clk);
        rst_n = 1'b0;
        drive(1'b1, 32'h002081B3, 32'h0, 32'hBBB, 32'h1);
        @(negedge clk);
        check("rst_mid", "valid", 32'(ex_valid), 32'd0);
        check("rst_mid", "ready", 32'(inst_ready), 32'd1);
        check("rst_mid", "op1", ex_op1, 32'd0);
        check("rst_mid", "op2", ex_op2, 32'd0);
        check("rst_mid", "rd_we_ill", {ex_rd, ex_we, ex_illegal, ex_alu_op}, 32'd0);
        rst_n = 1'b1;
        inst_valid = 1'b0;
        @(negedge clk);
        check("rst_mid2", "valid", 32'(ex_valid), 32'd0);

        // Random traffic against a 2-deep FIFO model
        model_q.delete();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic acc, xf;
            check("rnd", "valid", 32'(ex_valid), 32'(model_q.size() > 0));
            check("rnd", "ready", 32'(inst_ready), 32'(model_q.size() < 2));
            if (model_q.size() > 0) check_entry("rnd", model_q[0]);
            drive($urandom_range(0, 99) < 70, gen_inst(), $urandom, $urandom, $urandom);
            ex_ready = ($urandom_range(0, 99) < 60);
            flush = ($urandom_range(0, 99) < 3);
            acc = inst_valid && (model_q.size() < 2);
            xf = ex_ready && (model_q.size() > 0);
            if (flush) begin
                model_q.delete();
            end else begin
                if (xf) void'(model_q.pop_front());
                if (acc) model_q.push_back(ref_decode(inst, pc, rs1, rs2));
            end
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_issue.md
Name: alu_issue

Overview:
- Issue stage that drives the integer ALU.
- Decodes RV32I OP, OP-IMM, LUI and AUIPC instructions into ALU operands, ALU opcode and alu_op modifier, then registers them toward EX.
- Sits between decode/register-read and the ALU; holds results in a 2-entry skid buffer with valid/ready handshakes on both sides.
- Flags unsupported encodings as illegal.

Parameters:
- XLEN, 32, operand/PC width (only 32 supported).
- OPC_W, 8, width of the ALU opcode field.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  synchronous active-low reset.
- flush_i  in  1  drop all buffered and incoming instructions.
- inst_valid_i  in  1  upstream instruction valid.
- inst_ready_o  out  1  issue can accept (registered).
- inst_i  in  32  instruction word.
- pc_i  in  32  instruction PC.
- rs1_data_i  in  32  rs1 register value.
- rs2_data_i  in  32  rs2 register value.
- ex_valid_o  out  1  EX entry valid.
- ex_ready_i  in  1  ALU/EX consumes entry.
- ex_op1_o  out  32  ALU operand 1.
- ex_op2_o  out  32  ALU operand 2.
- ex_opcode_o  out  OPC_W  ALU opcode (shared ALU instruction constants).
- ex_alu_op_o  out  1  ALU modifier: SUB vs ADD, SRA vs SLT.
- ex_rd_o  out  5  destination register.
- ex_we_o  out  1  write rd (0 when illegal or rd==0).
- ex_illegal_o  out  1  unsupported encoding.

Behaviour:
- Reset (rst_ni low at a clock edge): ex_valid_o=0, all ex_* data outputs 0, inst_ready_o=1, skid buffer empty. Inputs are ignored while rst_ni is low.
- Handshakes:
  - Accept when inst_valid_i && inst_ready_o.
  - EX transfer when ex_valid_o && ex_ready_i.
  - ex_* outputs are stable while ex_valid_o && !ex_ready_i.
- Latency: accept into an empty stage gives ex_valid_o=1 on the next cycle. Full throughput of 1/cycle while ex_ready_i=1.
- Buffer FSM, states EMPTY / ONE (main full) / TWO (main + skid full):
  - EMPTY + accept -> ONE.
  - ONE + accept, no transfer -> TWO; the new item goes to skid.
  - ONE + transfer, no accept -> EMPTY.
  - ONE + both -> ONE; main is reloaded with the new item.
  - TWO + transfer -> ONE; skid moves to main.
  - No accept is possible in TWO.
  - inst_ready_o = (next state != TWO), registered.
  - Order is strictly FIFO.
- flush_i: the next state is EMPTY regardless of accept or transfer in the same cycle; the incoming item is discarded. flush_i has priority over everything except reset.
- Decode (combinational, captured at accept):
  - OP (0110011), funct7 0000000 / 0100000:
    - op1=rs1, op2=rs2.
    - Shifts (funct3 001/101): op2 = {27'b0, rs2[4:0]}.
    - SUB: ADD/SUB code, alu_op=1.
    - SRA: SRA/SLT code, alu_op=1.
    - SLT: SRA/SLT code, alu_op=0.
    - SLTU: SLTU code.
    - funct7 0100000 is valid only with funct3 000/101; any other funct7 is illegal.
  - OP-IMM (0010011):
    - op1=rs1, op2 = sign-extended imm[11:0].
    - SLTIU compares the sign-extended immediate unsigned.
    - SLLI: funct7 must be 0000000.
    - SRLI/SRAI: funct7 must be 0000000 / 0100000.
    - Shift-immediate op2 = zero-extended shamt inst[24:20].
    - Any other funct7 on a shift-immediate is illegal.
  - LUI: op1=0, op2={inst[31:12],12'b0}, ADD, alu_op=0.
  - AUIPC: op1=pc_i, op2={inst[31:12],12'b0}, ADD, alu_op=0.
  - Any other major opcode: illegal=1, we=0, op1=op2=0, ADD.
  - we = !illegal && rd!=0.
- Illegal instructions still flow through the buffer in order.

Decomposition:
- Shared package/header holds:
  - RV32I major opcode constants (OP, OP_IMM, LUI, AUIPC).
  - funct3/funct7 constants.
  - The existing ALU opcode constants (ADD, SUB, XOR, OR, AND, SLL, SRL, SRA, SLT, SLTU).
  - A packed issue-entry layout {op1, op2, opcode, alu_op, rd, we, illegal}.
- One natural sub-module, alu_issue_decode: pure combinational inst/rs/pc -> issue entry. The top level holds the skid buffer FSM.

Test Plan:
- ADD x3,x1,x2 (0x002081B3), rs1=5, rs2=7, ex_ready_i=1 -> next cycle ex_valid_o=1, op1=5, op2=7, opcode=ADD, alu_op=0, rd=3, we=1.
- SUB (0x402081B3) -> alu_op=1. SRAI x1,x2,4 (0x40415093), rs1=0x80000000 -> op2=4, opcode=SRA, alu_op=1. SLL with rs2=0x00000123 -> op2=3.
- ADDI x1,x0,-1 (0xFFF00093) -> op2=0xFFFFFFFF. LUI x5,0x12345 (0x123452B7) -> op1=0, op2=0x12345000. AUIPC with pc=0x100 -> op1=0x100.
- ex_ready_i=0, push 3 back-to-back -> 2 accepted, inst_ready_o=0 after the 2nd. Raise ex_ready_i -> entries delivered in order, 1/cycle, inst_ready_o returns 1.
- Stage in TWO, assert flush_i with inst_valid_i=1 -> next cycle ex_valid_o=0, inst_ready_o=1, the flushed and incoming items never appear.
- ECALL (0x00000073) and ADD with funct7=0000001 -> ex_illegal_o=1, ex_we_o=0. Assert rst_ni=0 mid-stream -> outputs match reset values on the next edge.
